// File: rtl/dec_scan.sv
// dec_scan: registered N-to-2**N one-hot decoder with a built-in sweep mode.
// In IDLE the output follows En/sel one clock later; a scan_start request
// walks a single hot bit across every output in order, then pulses done.
module dec_scan #(
  parameter int unsigned N         = 4,
  parameter bit          SCAN_DOWN = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              En,
  input  logic [N-1:0]      sel,
  input  logic              scan_start,
  input  logic              scan_abort,
  output logic [2**N-1:0]   DataOut,
  output logic [N-1:0]      idx,
  output logic              busy,
  output logic              done
);

  localparam int unsigned W = 2**N;

  // First and last sweep index depend only on direction.
  localparam logic [N-1:0] FirstIdx = SCAN_DOWN ? {N{1'b1}} : {N{1'b0}};
  localparam logic [N-1:0] LastIdx  = SCAN_DOWN ? {N{1'b0}} : {N{1'b1}};

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   cnt_q, cnt_d;
  logic [W-1:0]   data_q, data_d;
  logic [N-1:0]   cnt_step;

  function automatic logic [W-1:0] onehot(input logic [N-1:0] i);
    logic [W-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Counter value one step further along the sweep direction.
  always_comb begin
    if (SCAN_DOWN) begin
      cnt_step = cnt_q - {{(N-1){1'b0}}, 1'b1};
    end else begin
      cnt_step = cnt_q + {{(N-1){1'b0}}, 1'b1};
    end
  end

  // Next-state, next-counter and next-output decode; output defaults to all-zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = '0;
    unique case (state_q)
      StIdle: begin
        if (scan_start) begin
          state_d = StScan;
          cnt_d   = FirstIdx;
          data_d  = onehot(FirstIdx);
        end else if (En) begin
          data_d  = onehot(sel);
        end
      end
      StScan: begin
        if (scan_abort) begin
          state_d = StIdle;
        end else if (cnt_q == LastIdx) begin
          state_d = StDone;
        end else begin
          cnt_d   = cnt_step;
          data_d  = onehot(cnt_step);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, counter and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  // Status flags decode from the state register alone.
  always_comb begin
    DataOut = data_q;
    idx     = cnt_q;
    busy    = (state_q == StScan);
    done    = (state_q == StDone);
  end

endmodule

// File: tb/tb_dec_scan.sv
// Scoreboard bench for dec_scan: one up-sweep and one down-sweep instance share
// stimulus; a sweep-position model predicts outputs, a monitor compares them.
module tb_dec_scan;

  logic        clk;
  logic        reset_n;
  logic        En;
  logic [3:0]  sel;
  logic        scan_start;
  logic        scan_abort;
  logic [15:0] data_up, data_dn;
  logic [3:0]  idx_up, idx_dn;
  logic        busy_up, busy_dn, done_up, done_dn;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: sweep described as a position 0..15 along the sweep.
  bit m_scan = 0;
  bit m_done = 0;
  int m_pos  = 0;

  typedef struct {
    logic [15:0] du;
    logic [15:0] dd;
    logic [3:0]  iu;
    logic [3:0]  idn;
    logic        bz;
    logic        dn;
    bit          sc;
  } exp_t;

  exp_t q[$];

  dec_scan #(.N(4), .SCAN_DOWN(1'b0)) u_up (
    .clk(clk), .reset_n(reset_n), .En(En), .sel(sel), .scan_start(scan_start),
    .scan_abort(scan_abort), .DataOut(data_up), .idx(idx_up), .busy(busy_up), .done(done_up)
  );

  dec_scan #(.N(4), .SCAN_DOWN(1'b1)) u_dn (
    .clk(clk), .reset_n(reset_n), .En(En), .sel(sel), .scan_start(scan_start),
    .scan_abort(scan_abort), .DataOut(data_dn), .idx(idx_dn), .busy(busy_dn), .done(done_dn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, predict the post-edge outputs and queue them.
  task automatic step(input bit en, input logic [3:0] s, input bit st, input bit ab);
    exp_t e;
    En = en; sel = s; scan_start = st; scan_abort = ab;
    e.du = '0; e.dd = '0;
    if (m_done) begin
      m_done = 0;
    end else if (m_scan) begin
      if (ab) begin
        m_scan = 0;
      end else if (m_pos == 15) begin
        m_scan = 0;
        m_done = 1;
      end else begin
        m_pos++;
        e.du = 16'h0001 << m_pos;
        e.dd = 16'h8000 >> m_pos;
      end
    end else if (st) begin
      m_scan = 1;
      m_pos  = 0;
      e.du   = 16'h0001;
      e.dd   = 16'h8000;
    end else if (en) begin
      e.du = 16'h0001 << s;
      e.dd = e.du;
    end
    e.bz  = m_scan;
    e.dn  = m_done;
    e.sc  = m_scan;
    e.iu  = 4'(m_pos);
    e.idn = 4'(15 - m_pos);
    @(posedge clk);
    q.push_back(e);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " up DataOut"}, {16'h0, data_up}, 32'h0);
    check({tag, " dn DataOut"}, {16'h0, data_dn}, 32'h0);
    check({tag, " busy"}, {30'h0, busy_up, busy_dn}, 32'h0);
    check({tag, " done"}, {30'h0, done_up, done_dn}, 32'h0);
  endtask

  initial begin
    reset_n = 1'b0; En = 1'b0; sel = '0; scan_start = 1'b0; scan_abort = 1'b0;

    // Monitor: pops one expectation per cycle, compares away from the edge.
    fork
      forever begin
        @(negedge clk);
        if (reset_n) begin
          check("onehot up", {31'h0, ($countones(data_up) <= 1)}, 32'h1);
          check("onehot dn", {31'h0, ($countones(data_dn) <= 1)}, 32'h1);
        end
        if (q.size() > 0) begin
          exp_t e;
          e = q.pop_front();
          check("DataOut up", {16'h0, data_up}, {16'h0, e.du});
          check("DataOut dn", {16'h0, data_dn}, {16'h0, e.dd});
          check("busy", {30'h0, busy_up, busy_dn}, {30'h0, e.bz, e.bz});
          check("done", {30'h0, done_up, done_dn}, {30'h0, e.dn, e.dn});
          if (e.sc) begin
            check("idx up", {28'h0, idx_up}, {28'h0, e.iu});
            check("idx dn", {28'h0, idx_dn}, {28'h0, e.idn});
          end
        end
      end
    join_none

    // Reset state, with scan_start requested while reset is held.
    #2;
    scan_start = 1'b1;
    check_zero("reset");
    check("reset idx", {24'h0, idx_up, idx_dn}, 32'h0);
    repeat (2) @(posedge clk);
    #1 check_zero("reset held");
    @(negedge clk);
    #1 reset_n = 1'b1;
    scan_start = 1'b0;

    // Basic decode then disable.
    step(1, 4'hA, 0, 0);
    step(0, 4'hA, 0, 0);

    // Every {En, sel} combination in IDLE.
    for (int i = 0; i < 32; i++) step(i[4], i[3:0], 0, 0);

    // Full sweep from a single start pulse; En/sel noise must be ignored.
    step(0, 4'h0, 1, 0);
    for (int i = 0; i < 19; i++) step(1, 4'($urandom_range(0, 15)), 0, 0);

    // Abort once the sweep reaches position 5; abort in IDLE/DONE is harmless.
    step(0, 4'h0, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 4'h0, 0, 0);
    step(0, 4'h0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 4'h0, 0, 1);

    // scan_start held high: one sweep, DONE, back through IDLE, then a new sweep.
    for (int i = 0; i < 22; i++) step(0, 4'h0, 1, 0);
    for (int i = 0; i < 16; i++) step(0, 4'h0, 0, 0);

    // Asynchronous reset mid-sweep at position 9.
    step(0, 4'h0, 1, 0);
    for (int i = 0; i < 9; i++) step(0, 4'h0, 0, 0);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1 check_zero("async reset");
    m_scan = 0; m_done = 0; m_pos = 0;
    @(negedge clk);
    #1 reset_n = 1'b1;
    step(1, 4'h3, 0, 0);
    step(0, 4'h3, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
    end

    @(negedge clk);
    #1;
    check("scoreboard drained", q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
